// File: rtl/cdb_pkg.sv
// Shared types and helpers for the CDB arbiter: result entry layout and round-robin pick.
package cdb_pkg;

  localparam int unsigned CDB_DW  = 16;
  localparam int unsigned CDB_PW  = 5;
  localparam int unsigned CDB_TW  = 4;
  localparam int unsigned RR_MAX  = 8;

  typedef struct packed {
    logic [CDB_PW-1:0] pw;
    logic [CDB_DW-1:0] result;
    logic [CDB_TW-1:0] tag_rob;
    logic              exp;
  } cdb_entry_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req_mask scanning from ptr upward, wrapping modulo n (n <= RR_MAX).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req_mask,
                                       input logic [2:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned j;
    r.found = 1'b0;
    r.idx   = '0;
    j       = 0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      j = (32'(ptr) + i) % n;
      if (!r.found && (i < n) && req_mask[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Shallow per-requester result FIFO; flush drops all contents and any same-cycle push.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned EW    = 26,
  parameter int unsigned DEPTH = 2
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [EW-1:0]              entry_in,
  output logic [EW-1:0]              entry_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign entry_out = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= entry_in;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining per-unit result FIFOs onto one registered CDB port.
// Optional same-cycle bypass of empty FIFOs is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = CDB_DW,
  parameter int unsigned PW    = CDB_PW,
  parameter int unsigned TW    = CDB_TW
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       freeze_back,
  input  logic [N_REQ-1:0]           valid_req,
  output logic [N_REQ-1:0]           ready_req,
  input  logic [N_REQ*PW-1:0]        Pw_req,
  input  logic [N_REQ*DW-1:0]        Result_req,
  input  logic [N_REQ*TW-1:0]        tag_ROB_req,
  input  logic [N_REQ-1:0]           exp_req,
  output logic                       valid_cdb,
  output logic [PW-1:0]              Pw_cdb,
  output logic [DW-1:0]              Result_cdb,
  output logic [TW-1:0]              tag_ROB_cdb,
  output logic                       exp_cdb,
  output logic [$clog2(N_REQ)-1:0]   grant_cdb
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned EW = PW + DW + TW + 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [EW-1:0]       fifo_in  [N_REQ];
  logic [EW-1:0]       fifo_out [N_REQ];
  logic [CW-1:0]       count    [N_REQ];
  logic [N_REQ-1:0]    push;
  logic [N_REQ-1:0]    pop;
  logic [N_REQ-1:0]    byp;
  logic [N_REQ-1:0]    full;
  logic [N_REQ-1:0]    empty;
  logic [RR_MAX-1:0]   cand;
  rr_pick_t            pick;
  logic                arb_en;
  logic                sel;
  logic [GW-1:0]       win;
  logic [GW-1:0]       rr_ptr;
  logic [EW-1:0]       win_entry;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    assign fifo_in[g]   = {Pw_req[g*PW +: PW], Result_req[g*DW +: DW],
                           tag_ROB_req[g*TW +: TW], exp_req[g]};
    assign ready_req[g] = (count[g] != CW'(DEPTH));

    cdb_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push[g]),
      .pop       (pop[g]),
      .entry_in  (fifo_in[g]),
      .entry_out (fifo_out[g]),
      .count     (count[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // Candidate selection, pops and pushes for this cycle.
  always_comb begin
    cand = '0;
`ifdef CDB_BYPASS_EN
    cand[N_REQ-1:0] = ~empty | valid_req;
`else
    cand[N_REQ-1:0] = ~empty;
`endif
    pick      = rr_pick(cand, 3'(rr_ptr), N_REQ);
    arb_en    = !freeze_back && !flush;
    win       = GW'(pick.idx);
    sel       = 1'b0;
    pop       = '0;
    byp       = '0;
    push      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sel     = arb_en && pick.found && (pick.idx == 3'(i));
      pop[i]  = sel && !empty[i];
      byp[i]  = sel && empty[i];
      push[i] = valid_req[i] && !full[i] && !byp[i];
    end
    win_entry = empty[win] ? fifo_in[win] : fifo_out[win];
  end

  // Broadcast register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_cdb   <= 1'b0;
      Pw_cdb      <= '0;
      Result_cdb  <= '0;
      tag_ROB_cdb <= '0;
      exp_cdb     <= 1'b0;
      grant_cdb   <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      valid_cdb <= 1'b0;
      rr_ptr    <= '0;
    end else if (!freeze_back) begin
      valid_cdb <= pick.found;
      if (pick.found) begin
        {Pw_cdb, Result_cdb, tag_ROB_cdb, exp_cdb} <= win_entry;
        grant_cdb <= win;
        rr_ptr    <= (win == GW'(N_REQ - 1)) ? '0 : win + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, corner sequences, random vs. queue model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int DW    = 16;
  localparam int PW    = 5;
  localparam int TW    = 4;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush, freeze_back;
  logic [N-1:0]    valid_req, ready_req, exp_flat;
  logic [N*PW-1:0] pw_flat;
  logic [N*DW-1:0] res_flat;
  logic [N*TW-1:0] tag_flat;
  logic            valid_cdb, exp_cdb;
  logic [PW-1:0]   Pw_cdb;
  logic [DW-1:0]   Result_cdb;
  logic [TW-1:0]   tag_ROB_cdb;
  logic [1:0]      grant_cdb;
  cdb_entry_t      in_e [N];

  always #5 clk = ~clk;

  always_comb begin
    pw_flat = '0; res_flat = '0; tag_flat = '0; exp_flat = '0;
    for (int i = 0; i < N; i++) begin
      pw_flat[i*PW +: PW]  = in_e[i].pw;
      res_flat[i*DW +: DW] = in_e[i].result;
      tag_flat[i*TW +: TW] = in_e[i].tag_rob;
      exp_flat[i]          = in_e[i].exp;
    end
  end

  cdb_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .DW(DW), .PW(PW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
    .valid_req(valid_req), .ready_req(ready_req),
    .Pw_req(pw_flat), .Result_req(res_flat), .tag_ROB_req(tag_flat), .exp_req(exp_flat),
    .valid_cdb(valid_cdb), .Pw_cdb(Pw_cdb), .Result_cdb(Result_cdb),
    .tag_ROB_cdb(tag_ROB_cdb), .exp_cdb(exp_cdb), .grant_cdb(grant_cdb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester plus the broadcast register contents.
  cdb_entry_t q [N][$];
  cdb_entry_t m_out;
  bit         m_valid;
  int         m_rr, m_grant;

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    m_valid = 0; m_rr = 0; m_grant = 0; m_out = '0;
  endtask

  task automatic model_step();
    bit acc [N];
    bit found;
    int win;
    if (flush) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_valid = 0;
      m_rr    = 0;
    end else begin
      for (int i = 0; i < N; i++) acc[i] = valid_req[i] && (q[i].size() < DEPTH);
      if (!freeze_back) begin
        found = 0; win = 0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (!found && (q[j].size() > 0 || (BYP && acc[j]))) begin
            found = 1; win = j;
          end
        end
        m_valid = found;
        if (found) begin
          if (q[win].size() > 0) m_out = q[win].pop_front();
          else begin m_out = in_e[win]; acc[win] = 0; end
          m_grant = win;
          m_rr    = (win + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) if (acc[i]) q[i].push_back(in_e[i]);
    end
  endtask

  // One clock: check ready, advance model, clock DUT, compare broadcast.
  task automatic cycle();
    logic [N-1:0] mr;
    for (int i = 0; i < N; i++) mr[i] = (q[i].size() < DEPTH);
    check("ready_req", 32'(ready_req), 32'(mr));
    model_step();
    @(posedge clk); #1;
    check("valid_cdb", 32'(valid_cdb), 32'(m_valid));
    if (m_valid) begin
      check("Pw_cdb", 32'(Pw_cdb), 32'(m_out.pw));
      check("Result_cdb", 32'(Result_cdb), 32'(m_out.result));
      check("tag_ROB_cdb", 32'(tag_ROB_cdb), 32'(m_out.tag_rob));
      check("exp_cdb", 32'(exp_cdb), 32'(m_out.exp));
      check("grant_cdb", 32'(grant_cdb), 32'(m_grant));
    end
  endtask

  task automatic set_entry(input int i, input int pw, input int res, input int tag, input bit e);
    in_e[i].pw = 5'(pw); in_e[i].result = 16'(res); in_e[i].tag_rob = 4'(tag); in_e[i].exp = e;
  endtask

  task automatic idle_inputs();
    valid_req = '0; flush = 0; freeze_back = 0;
  endtask

  task automatic do_flush();
    idle_inputs(); flush = 1; cycle(); flush = 0;
  endtask

  typedef struct {
    logic [2:0] vin;
    logic [2:0] ready;
    logic       vcdb;
    int         grant;
    int         pw;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{3'b111, 3'b111, 1'b0, 0, 0};
    tbl[1] = '{3'b111, 3'b111, 1'b1, 0, 1};
    tbl[2] = '{3'b111, 3'b001, 1'b1, 1, 2};
    tbl[3] = '{3'b111, 3'b010, 1'b1, 2, 3};
    tbl[4] = '{3'b111, 3'b100, 1'b1, 0, 4};
    tbl[5] = '{3'b111, 3'b001, 1'b1, 1, 5};
    tbl[6] = '{3'b000, 3'b010, 1'b1, 2, 6};
    tbl[7] = '{3'b000, 3'b110, 1'b1, 0, 7};

    rst = 1; idle_inputs();
    for (int i = 0; i < N; i++) in_e[i] = '0;
    model_reset();
    #12;
    check("rst_valid", 32'(valid_cdb), 0);
    check("rst_ready", 32'(ready_req), 32'h7);
    check("rst_grant", 32'(grant_cdb), 0);
    check("rst_pw", 32'(Pw_cdb), 0);
    @(negedge clk); rst = 0;

`ifndef CDB_BYPASS_EN
    // Round-robin table: all push for 6 cycles, then drain.
    for (int r = 0; r < 8; r++) begin
      valid_req = tbl[r].vin;
      for (int i = 0; i < N; i++) set_entry(i, r*3 + i + 1, r*16 + i, r, i == 2);
      check("tbl_ready", 32'(ready_req), 32'(tbl[r].ready));
      cycle();
      check("tbl_valid", 32'(valid_cdb), 32'(tbl[r].vcdb));
      if (tbl[r].vcdb) begin
        check("tbl_grant", 32'(grant_cdb), 32'(tbl[r].grant));
        check("tbl_pw", 32'(Pw_cdb), 32'(tbl[r].pw));
      end
    end
`endif

    // Single requester latency.
    do_flush();
    set_entry(0, 7, 16'h1234, 3, 0);
    valid_req = 3'b001;
    cycle();
    valid_req = '0;
`ifdef CDB_BYPASS_EN
    check("single_valid_c1", 32'(valid_cdb), 1);
`else
    check("single_valid_c1", 32'(valid_cdb), 0);
    cycle();
`endif
    check("single_valid", 32'(valid_cdb), 1);
    check("single_pw", 32'(Pw_cdb), 7);
    check("single_result", 32'(Result_cdb), 32'h1234);
    check("single_tag", 32'(tag_ROB_cdb), 3);
    check("single_grant", 32'(grant_cdb), 0);
    cycle();

    // Full FIFO under freeze, then drain in order.
    do_flush();
    freeze_back = 1; valid_req = 3'b010;
    for (int k = 0; k < 3; k++) begin
      set_entry(1, 11 + k, 100 + k, k, 0);
      check("full_ready1", 32'(ready_req[1]), (k < 2) ? 1 : 0);
      cycle();
    end
    check("full_frozen_valid", 32'(valid_cdb), 0);
    idle_inputs();
    cycle();
    check("full_first_pw", 32'(Pw_cdb), 11);
    check("full_first_grant", 32'(grant_cdb), 1);
    cycle();
    check("full_second_pw", 32'(Pw_cdb), 12);
    cycle();
    check("full_drained", 32'(valid_cdb), 0);

    // Flush with 4 entries held and a concurrent push.
    freeze_back = 1; valid_req = 3'b101;
    set_entry(0, 20, 20, 1, 0); cycle();
    set_entry(0, 21, 21, 2, 0); set_entry(2, 22, 22, 3, 1); cycle();
    valid_req = 3'b111; flush = 1;
    cycle();
    check("flush_valid", 32'(valid_cdb), 0);
    check("flush_ready", 32'(ready_req), 32'h7);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("flush_no_stale", 32'(valid_cdb), 0);
    end
    valid_req = 3'b101;
    set_entry(0, 24, 24, 4, 0); set_entry(2, 25, 25, 5, 0);
    cycle();
    valid_req = '0;
    for (int k = 0; k < 3 && !valid_cdb; k++) cycle();
    check("flush_rr_grant", 32'(grant_cdb), 0);
    cycle(); cycle();

    // Freeze hold.
    do_flush();
    valid_req = 3'b100; set_entry(2, 9, 16'h0909, 9, 0);
    cycle();
    valid_req = '0;
    for (int k = 0; k < 3 && !valid_cdb; k++) cycle();
    check("hold_valid", 32'(valid_cdb), 1);
    check("hold_pw", 32'(Pw_cdb), 9);
    freeze_back = 1; valid_req = 3'b011;
    set_entry(0, 30, 30, 0, 0); set_entry(1, 31, 31, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      valid_req = '0;
      check("hold_stable_valid", 32'(valid_cdb), 1);
      check("hold_stable_pw", 32'(Pw_cdb), 9);
    end
    freeze_back = 0;
    cycle();
    check("hold_next_grant", 32'(grant_cdb), 0);
    cycle(); cycle();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      valid_req   = 3'($urandom);
      flush       = ($urandom_range(0, 29) == 0);
      freeze_back = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        set_entry(i, int'($urandom), int'($urandom), int'($urandom), 1'($urandom));
      cycle();
    end

    // Asynchronous reset in the middle of a broadcast.
    idle_inputs(); valid_req = 3'b111;
    cycle(); cycle(); cycle();
    #2 rst = 1;
    #1;
    check("arst_valid", 32'(valid_cdb), 0);
    check("arst_ready", 32'(ready_req), 32'h7);
    check("arst_pw", 32'(Pw_cdb), 0);
    check("arst_result", 32'(Result_cdb), 0);
    check("arst_grant", 32'(grant_cdb), 0);
    model_reset();
    idle_inputs();
    @(negedge clk); rst = 0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
